// File: rtl/writeback_pc_update.sv
// Writeback/PC-update stage: 15x64 register file, PC, retire counter and status FSM; WB_BYPASS_EN forwards write data to the read ports.
// Latency: reads are combinational, state updates on the retiring edge; no backpressure, commit=0 simply holds state.
module writeback_pc_update #(
  parameter logic [63:0] PC_RESET = 64'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        commit,
  input  logic [3:0]  in_code,
  input  logic [3:0]  r_a,
  input  logic [3:0]  r_b,
  input  logic [63:0] val_e,
  input  logic [63:0] val_m,
  input  logic [63:0] val_p,
  input  logic [63:0] val_c,
  input  logic        cnd,
  input  logic        bad_instr,
  input  logic        bad_mem2,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  output logic [63:0] val_a,
  output logic [63:0] val_b,
  output logic [63:0] pc,
  output logic [1:0]  stat,
  output logic [63:0] retired
);

  typedef enum logic [1:0] {ST_AOK = 2'd0, ST_HLT = 2'd1, ST_ADR = 2'd2, ST_INS = 2'd3} stat_e;

  localparam logic [3:0] I_HALT   = 4'd0;
  localparam logic [3:0] I_CMOV   = 4'd2;
  localparam logic [3:0] I_IRMOV  = 4'd3;
  localparam logic [3:0] I_MRMOV  = 4'd5;
  localparam logic [3:0] I_OPQ    = 4'd6;
  localparam logic [3:0] I_JXX    = 4'd7;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSH   = 4'd10;
  localparam logic [3:0] I_POP    = 4'd11;
  localparam logic [3:0] REG_RSP  = 4'd4;
  localparam logic [3:0] REG_NONE = 4'hF;

  stat_e       state_q, state_d;
  logic [63:0] rf [0:14];
  logic [3:0]  dst_e, dst_m;
  logic [63:0] new_pc;
  logic        retire, wr_en;

  always_comb begin
    dst_e = REG_NONE;
    case (in_code)
      I_CMOV:                       dst_e = cnd ? r_b : REG_NONE;
      I_IRMOV, I_OPQ:               dst_e = r_b;
      I_CALL, I_RET, I_PUSH, I_POP: dst_e = REG_RSP;
      default:                      dst_e = REG_NONE;
    endcase
  end

  assign dst_m = (in_code == I_MRMOV || in_code == I_POP) ? r_a : REG_NONE;

  always_comb begin
    new_pc = val_p;
    if (in_code == I_CALL || (in_code == I_JXX && cnd)) new_pc = val_c;
    else if (in_code == I_RET)                          new_pc = val_m;
  end

  assign retire = commit && (state_q == ST_AOK);

  always_comb begin
    state_d = state_q;
    if (retire) begin
      if (bad_instr)              state_d = ST_INS;
      else if (bad_mem2)          state_d = ST_ADR;
      else if (in_code == I_HALT) state_d = ST_HLT;
    end
  end

  // The faulting instruction still retires, but must not touch the register file.
  assign wr_en = retire && (state_d == ST_AOK);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_AOK;
      pc      <= PC_RESET;
      retired <= 64'd0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        pc      <= new_pc;
        retired <= retired + 64'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 15; i++) rf[i] <= 64'd0;
    end else if (wr_en) begin
      for (int i = 0; i < 15; i++) begin
        if (dst_m == 4'(i))      rf[i] <= val_m;
        else if (dst_e == 4'(i)) rf[i] <= val_e;
      end
    end
  end

  function automatic logic [63:0] read_port(input logic [3:0] src);
    logic [63:0] data;
    data = (src == REG_NONE) ? 64'd0 : rf[src];
`ifdef WB_BYPASS_EN
    if (wr_en && src != REG_NONE) begin
      if (src == dst_m)      data = val_m;
      else if (src == dst_e) data = val_e;
    end
`endif
    return data;
  endfunction

  assign val_a = read_port(src_a);
  assign val_b = read_port(src_b);
  assign stat  = state_q;

endmodule

// File: tb/tb_writeback_pc_update.sv
// Bench for writeback_pc_update: directed vector table, hand-written reset/bypass sequences, randomized run against a reference model.
module tb_writeback_pc_update;

  localparam logic [63:0] PC_RST = 64'h1000;

  logic        clock = 1'b0;
  logic        reset_n, commit, cnd, bad_instr, bad_mem2;
  logic [3:0]  in_code, r_a, r_b, src_a, src_b;
  logic [63:0] val_e, val_m, val_p, val_c;
  logic [63:0] val_a, val_b, pc, retired;
  logic [1:0]  stat;

  int checks = 0;
  int failures = 0;

  // Reference state
  logic [63:0] m_regs [15];
  logic [63:0] m_pc, m_ret;
  int          m_stat;

  writeback_pc_update #(.PC_RESET(PC_RST)) dut (
    .clock(clock), .reset_n(reset_n), .commit(commit), .in_code(in_code),
    .r_a(r_a), .r_b(r_b), .val_e(val_e), .val_m(val_m), .val_p(val_p), .val_c(val_c),
    .cnd(cnd), .bad_instr(bad_instr), .bad_mem2(bad_mem2), .src_a(src_a), .src_b(src_b),
    .val_a(val_a), .val_b(val_b), .pc(pc), .stat(stat), .retired(retired)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Destination the instruction targets with val_e / val_m; -1 = no write.
  function automatic int e_target();
    if ((in_code == 3 || in_code == 6 || (in_code == 2 && cnd)) && r_b != 15) return int'(r_b);
    if (in_code >= 8 && in_code <= 11) return 4;
    return -1;
  endfunction

  function automatic int m_target();
    if ((in_code == 5 || in_code == 11) && r_a != 15) return int'(r_a);
    return -1;
  endfunction

  function automatic bit will_write();
    return commit && m_stat == 0 && !bad_instr && !bad_mem2 && in_code != 0;
  endfunction

  function automatic logic [63:0] model_read(input logic [3:0] src);
    if (src == 15) return 64'd0;
`ifdef WB_BYPASS_EN
    if (will_write() && m_target() == int'(src)) return val_m;
    if (will_write() && e_target() == int'(src)) return val_e;
`endif
    return m_regs[src];
  endfunction

  task automatic model_reset();
    foreach (m_regs[i]) m_regs[i] = 64'd0;
    m_pc = PC_RST; m_ret = 64'd0; m_stat = 0;
  endtask

  task automatic model_step();
    bit wr;
    if (!commit || m_stat != 0) return;
    wr = will_write();
    if (wr && e_target() >= 0) m_regs[e_target()] = val_e;
    if (wr && m_target() >= 0) m_regs[m_target()] = val_m;   // memory data wins
    if (in_code == 9)                                m_pc = val_m;
    else if (in_code == 8 || (in_code == 7 && cnd))  m_pc = val_c;
    else                                             m_pc = val_p;
    m_ret = m_ret + 1;
    m_stat = bad_instr ? 3 : bad_mem2 ? 2 : (in_code == 0) ? 1 : 0;
  endtask

  task automatic drive(input logic [3:0] c, input logic [3:0] a, input logic [3:0] b,
                       input logic [63:0] e, input logic [63:0] m, input logic [63:0] p,
                       input logic [63:0] k, input logic cd, input logic bi, input logic bm,
                       input logic cm);
    in_code = c; r_a = a; r_b = b; val_e = e; val_m = m; val_p = p; val_c = k;
    cnd = cd; bad_instr = bi; bad_mem2 = bm; commit = cm;
  endtask

  // Called a little after a rising edge; leaves the bench just after reset release.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_pc", pc, PC_RST);
    check("rst_stat", 64'(stat), 64'd0);
    check("rst_retired", retired, 64'd0);
    #2 reset_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  code, ra, rb;
    logic [63:0] ve, vm, vp, vc;
    logic        cd, bi, bm, cm;
    logic [3:0]  chk;
    logic [63:0] e_pc;
    logic [1:0]  e_stat;
    logic [63:0] e_ret, e_reg;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{4'd3,  4'hF, 4'd3, 64'h5,   64'h0,    64'h100A, 64'h0,  1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 64'h100A, 2'd0, 64'd1, 64'h5};
    vecs[1]  = '{4'd11, 4'd4, 4'hF, 64'h100, 64'h77,   64'h100C, 64'h0,  1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 64'h100C, 2'd0, 64'd2, 64'h77};
    vecs[2]  = '{4'd7,  4'hF, 4'hF, 64'h0,   64'h0,    64'h9,    64'h40, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 64'h9,    2'd0, 64'd3, 64'h77};
    vecs[3]  = '{4'd7,  4'hF, 4'hF, 64'h0,   64'h0,    64'h9,    64'h40, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 64'h40,   2'd0, 64'd4, 64'h77};
    vecs[4]  = '{4'd9,  4'hF, 4'hF, 64'h88,  64'h20,   64'h50,   64'h0,  1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 64'h20,   2'd0, 64'd5, 64'h88};
    vecs[5]  = '{4'd6,  4'hF, 4'd2, 64'h9,   64'h0,    64'h30,   64'h0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 64'h20,   2'd0, 64'd5, 64'h0};
    vecs[6]  = '{4'd2,  4'd1, 4'd5, 64'h33,  64'h0,    64'h60,   64'h0,  1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 64'h60,   2'd0, 64'd6, 64'h0};
    vecs[7]  = '{4'd2,  4'd1, 4'd5, 64'h33,  64'h0,    64'h62,   64'h0,  1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 64'h62,   2'd0, 64'd7, 64'h33};
    vecs[8]  = '{4'd5,  4'd6, 4'hF, 64'h1,   64'hDEAD, 64'h70,   64'h0,  1'b0, 1'b0, 1'b0, 1'b1, 4'd6, 64'h70,   2'd0, 64'd8, 64'hDEAD};
    vecs[9]  = '{4'd3,  4'hF, 4'd7, 64'h55,  64'h0,    64'h80,   64'h0,  1'b0, 1'b1, 1'b1, 1'b1, 4'd7, 64'h80,   2'd3, 64'd9, 64'h0};
    vecs[10] = '{4'd3,  4'hF, 4'd7, 64'h66,  64'h0,    64'h90,   64'h0,  1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 64'h80,   2'd3, 64'd9, 64'h0};
    vecs[11] = '{4'd6,  4'hF, 4'd3, 64'h99,  64'h0,    64'hA0,   64'h0,  1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 64'h80,   2'd3, 64'd9, 64'h5};

    reset_n = 1'b0; src_a = 4'hF; src_b = 4'hF;
    drive(4'd1, 4'hF, 4'hF, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    check("reset_pc", pc, PC_RST);
    check("reset_stat", 64'(stat), 64'd0);
    check("reset_retired", retired, 64'd0);
    src_a = 4'd0;
    #1 check("reset_reg0", val_a, 64'd0);
    @(posedge clock); #1 reset_n = 1'b1;

    // Directed vector table
    foreach (vecs[i]) begin
      drive(vecs[i].code, vecs[i].ra, vecs[i].rb, vecs[i].ve, vecs[i].vm, vecs[i].vp,
            vecs[i].vc, vecs[i].cd, vecs[i].bi, vecs[i].bm, vecs[i].cm);
      src_a = 4'hF;
      @(posedge clock); #1;
      commit = 1'b0; src_a = vecs[i].chk;
      #1;
      check($sformatf("vec%0d_pc", i), pc, vecs[i].e_pc);
      check($sformatf("vec%0d_stat", i), 64'(stat), 64'(vecs[i].e_stat));
      check($sformatf("vec%0d_retired", i), retired, vecs[i].e_ret);
      check($sformatf("vec%0d_reg", i), val_a, vecs[i].e_reg);
    end

    // Halt is terminal
    do_reset();
    drive(4'd0, 4'hF, 4'hF, 0, 0, 64'h1002, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clock); #1;
    drive(4'd3, 4'hF, 4'd1, 64'h7, 0, 64'h1004, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("hlt_stat", 64'(stat), 64'd1);
    check("hlt_pc", pc, 64'h1002);
    @(posedge clock); #1;
    commit = 1'b0; src_a = 4'd1;
    #1;
    check("hlt_hold_pc", pc, 64'h1002);
    check("hlt_hold_retired", retired, 64'd1);
    check("hlt_hold_reg1", val_a, 64'd0);

    // Address error on pushq: rsp untouched, pc still advances
    do_reset();
    drive(4'd10, 4'd2, 4'hF, 64'h200, 0, 64'h1010, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clock); #1;
    commit = 1'b0; src_a = 4'd4;
    #1;
    check("adr_stat", 64'(stat), 64'd2);
    check("adr_pc", pc, 64'h1010);
    check("adr_rsp", val_a, 64'd0);

    // Reset asserted mid-cycle discards the pending retirement
    do_reset();
    drive(4'd3, 4'hF, 4'd3, 64'h5, 0, 64'h2000, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clock); #1;
    drive(4'd3, 4'hF, 4'd3, 64'h5, 0, 64'h3000, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("pre_mid_pc", pc, 64'h2000);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_pc", pc, PC_RST);
    check("mid_rst_retired", retired, 64'd0);
    @(posedge clock); #1;
    src_a = 4'd3;
    check("held_rst_retired", retired, 64'd0);
    check("held_rst_pc", pc, PC_RST);
    check("held_rst_reg3", val_a, model_read_reset());
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("post_rst_retired", retired, 64'd1);
    check("post_rst_pc", pc, 64'h3000);

    // Read port during a write to the same register
    drive(4'd3, 4'hF, 4'd3, 64'hAB, 0, 64'h3010, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    src_a = 4'd3; src_b = 4'hF;
    #2;
`ifdef WB_BYPASS_EN
    check("bypass_val_a", val_a, 64'hAB);
`else
    check("bypass_val_a", val_a, 64'h5);
`endif
    check("bypass_none_b", val_b, 64'd0);
    @(posedge clock); #1;
    commit = 1'b0;
    #1 check("after_write_val_a", val_a, 64'hAB);

    // Randomized run against the reference model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic [3:0] c;
      c = 4'($urandom_range(1, 11));
      if ($urandom_range(0, 40) == 0) c = 4'd0;
      drive(c, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 30) == 0),
            1'($urandom_range(0, 30) == 0), 1'($urandom_range(0, 4) != 0));
      src_a = 4'($urandom_range(0, 15));
      src_b = 4'($urandom_range(0, 15));
      #2;
      check("rnd_val_a", val_a, model_read(src_a));
      check("rnd_val_b", val_b, model_read(src_b));
      @(posedge clock); #1;
      model_step();
      check("rnd_pc", pc, m_pc);
      check("rnd_stat", 64'(stat), 64'(m_stat));
      check("rnd_retired", retired, m_ret);
      if (m_stat != 0 && $urandom_range(0, 3) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Register contents are always zero while reset is held.
  function automatic logic [63:0] model_read_reset();
    return 64'd0;
  endfunction

endmodule

// File: doc/writeback_pc_update.md
WRITEBACK_PC_UPDATE -- requirements
Module: writeback_pc_update

Interface
REQ-001 SHALL have parameter PC_RESET, default 64'd0, meaning the PC value loaded on reset.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port commit  input  1  current instruction is complete and may retire this edge.
REQ-005 SHALL have port in_code  input  4  instruction code: 0 halt, 1 nop, 2 cmovXX, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX, 8 call, 9 ret, 10 pushq, 11 popq.
REQ-006 SHALL have port r_a, r_b  input  4 each  register specifiers; 4'hF means none.
REQ-007 SHALL have ports val_e, val_m, val_p, val_c  input  64 each  ALU result, memory read data, next sequential PC, constant word.
REQ-008 SHALL have port cnd  input  1  condition outcome for cmovXX/jXX.
REQ-009 SHALL have ports bad_instr, bad_mem2  input  1 each  invalid-instruction flag and memory-address-error flag.
REQ-010 SHALL have ports src_a, src_b  input  4 each  decode read addresses.
REQ-011 SHALL have ports val_a, val_b  output  64 each  combinational register-file read data; 64'd0 when source is 4'hF.
REQ-012 SHALL have port pc  output  64  registered program counter.
REQ-013 SHALL have port stat  output  2  registered status: 0 AOK, 1 HLT, 2 ADR, 3 INS.
REQ-014 SHALL have port retired  output  64  registered count of retired instructions.

Function
REQ-015 SHALL hold 15 registers x 64 bits (indices 0-14); index 15 never written.
REQ-016 SHALL compute dst_e: r_b for irmovq, OPq, and cmovXX with cnd=1; 4 (rsp) for call, ret, pushq, popq; else 15.
REQ-017 SHALL compute dst_m: r_a for mrmovq and popq; else 15.
REQ-018 SHALL, on a rising edge with commit=1 and stat=AOK, write val_e to dst_e and val_m to dst_m; when dst_e==dst_m!=15, val_m SHALL win.
REQ-019 SHALL compute new PC: val_c for call and for jXX with cnd=1; val_m for ret; val_p otherwise.
REQ-020 SHALL, on a retiring edge, load new PC into pc and increment retired by 1, wrapping modulo 2^64.
REQ-021 SHALL implement status FSM AOK->{INS, ADR, HLT} on retiring edge, priority bad_instr (INS) > bad_mem2 (ADR) > in_code==0 (HLT); otherwise remain AOK.
REQ-022 SHALL treat INS, ADR, HLT as terminal until reset: no register writes, pc, retired and stat held, commit ignored.
REQ-023 SHALL, on the faulting edge, suppress register writes but still load pc with new PC and increment retired.
REQ-024 SHALL, when commit=0, hold all state regardless of other inputs.

Reset
REQ-025 SHALL, on reset_n low, immediately set pc=PC_RESET, stat=AOK, retired=0, and all 15 registers to 0, independent of clock.
REQ-026 SHALL, if reset asserts mid-cycle with commit=1, discard the pending retirement; first retirement occurs on the first rising edge after reset_n is high.

Configuration
REQ-027 SHALL, with macro WB_BYPASS_EN defined, return on val_a/val_b the data being written this cycle (val_m priority over val_e) when src matches an active dst_m/dst_e and retirement is enabled.
REQ-028 SHALL, without WB_BYPASS_EN, return only the stored register value (pre-edge contents).

Verification
REQ-029 SHALL cover: reset, irmovq r_b=3 val_e=5 commit=1 -> reg3=5, pc=val_p, retired=1, stat=0.
REQ-030 SHALL cover: popq r_a=4 val_e=0x100 val_m=0x77 -> rsp=0x77 (M priority).
REQ-031 SHALL cover: jXX cnd=0 val_c=0x40 val_p=0x9 -> pc=0x9; cnd=1 -> pc=0x40; ret val_m=0x20 -> pc=0x20.
REQ-032 SHALL cover: bad_instr=1 and bad_mem2=1 together -> stat=3, no register write; subsequent irmovq edges -> pc, regs, retired unchanged.
REQ-033 SHALL cover: commit=0 with OPq r_b=2 val_e=9 -> reg2, pc, retired unchanged; reset_n low mid-cycle -> pc=PC_RESET immediately.
REQ-034 SHALL cover: src_a=3 while irmovq writes 3 with val_e=0xAB -> val_a=0xAB before the edge with WB_BYPASS_EN, old value without it.
